// File: rtl/pulse_pkg.sv
// pulse_pkg: shared state encoding, parameter defaults and sizing helpers for pulse_stretcher.
`default_nettype none

package pulse_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam int HIGH_CYCLES_DEF = 8;
  localparam int GAP_CYCLES_DEF  = 2;
  localparam int PEND_W_DEF      = 4;

  // Counter only ever holds (length-1), so clog2 of the longer phase suffices.
  function automatic int cnt_width(input int high_cycles, input int gap_cycles);
    int longest;
    longest = (high_cycles > gap_cycles) ? high_cycles : gap_cycles;
    return (longest < 2) ? 1 : $clog2(longest);
  endfunction

  function automatic int pend_max(input int pend_w);
    return (1 << pend_w) - 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/stretch_cnt.sv
// stretch_cnt: loadable down-counter that stops at zero, with a registered zero flag.
`default_nettype none

module stretch_cnt #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      zero <= 1'b1;
    end else if (load) begin
      cnt  <= load_val;
      zero <= (load_val == '0);
    end else if (!zero) begin
      cnt  <= cnt - W'(1);
      zero <= (cnt == W'(1));
    end
  end

endmodule

`default_nettype wire

// File: rtl/pulse_stretcher.sv
// pulse_stretcher: strobes -> HIGH_CYCLES windows separated by GAP_CYCLES, with a pending queue.
// Optional: PULSE_STRETCH_RETRIGGER_EN makes strobes during HIGH extend the window instead of queuing.
`default_nettype none

module pulse_stretcher
  import pulse_pkg::*;
#(
  parameter int HIGH_CYCLES = HIGH_CYCLES_DEF,
  parameter int GAP_CYCLES  = GAP_CYCLES_DEF,
  parameter int PEND_W      = PEND_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sig_pulse,
  input  logic              ovf_clr,
  output logic              sig_level,
  output logic              busy,
  output logic [PEND_W-1:0] pend_cnt,
  output logic              ovf
);

  localparam int                CNT_W     = cnt_width(HIGH_CYCLES, GAP_CYCLES);
  localparam logic [CNT_W-1:0]  HIGH_LOAD = CNT_W'(HIGH_CYCLES - 1);
  localparam logic [CNT_W-1:0]  GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX  = PEND_W'(pend_max(PEND_W));

`ifdef PULSE_STRETCH_RETRIGGER_EN
  localparam bit RETRIGGER = 1'b1;
`else
  localparam bit RETRIGGER = 1'b0;
`endif

  generate
    if (HIGH_CYCLES < 1) begin : g_bad_high
      $error("pulse_stretcher: HIGH_CYCLES must be >= 1");
    end
    if (GAP_CYCLES < 1) begin : g_bad_gap
      $error("pulse_stretcher: GAP_CYCLES must be >= 1");
    end
  endgenerate

  state_t             state;
  state_t             state_nxt;
  logic [PEND_W-1:0]  pend_nxt;
  logic               queue;
  logic               ovf_set;
  logic               cnt_load;
  logic [CNT_W-1:0]   cnt_val;
  logic               cnt_zero;

  stretch_cnt #(
    .W (CNT_W)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_val),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_nxt = state;
    pend_nxt  = pend_cnt;
    queue     = 1'b0;
    ovf_set   = 1'b0;
    cnt_load  = 1'b0;
    cnt_val   = HIGH_LOAD;

    case (state)
      IDLE: begin
        if (sig_pulse) begin
          state_nxt = HIGH;
          cnt_load  = 1'b1;
        end
      end
      HIGH: begin
        if (RETRIGGER && sig_pulse) begin
          cnt_load = 1'b1;
        end else begin
          queue = sig_pulse;
          if (cnt_zero) begin
            state_nxt = GAP;
            cnt_load  = 1'b1;
            cnt_val   = GAP_LOAD;
          end
        end
      end
      GAP: begin
        if (cnt_zero) begin
          if (pend_cnt != '0) begin
            // Oldest queued event starts now; a same-cycle strobe takes its slot.
            state_nxt = HIGH;
            cnt_load  = 1'b1;
            if (!sig_pulse) begin
              pend_nxt = pend_cnt - PEND_W'(1);
            end
          end else if (sig_pulse) begin
            state_nxt = HIGH;
            cnt_load  = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          queue = sig_pulse;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    if (queue) begin
      if (pend_cnt == PEND_MAX) begin
        ovf_set = 1'b1;
      end else begin
        pend_nxt = pend_cnt + PEND_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pend_cnt  <= '0;
      sig_level <= 1'b0;
      busy      <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      state     <= state_nxt;
      pend_cnt  <= pend_nxt;
      sig_level <= (state_nxt == HIGH);
      busy      <= (state_nxt != IDLE);
      if (ovf_set) begin
        ovf <= 1'b1;
      end else if (ovf_clr) begin
        ovf <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pulse_stretcher.sv
// tb_pulse_stretcher: directed scenarios checked every cycle against a window-timeline model.
`default_nettype none

module tb_pulse_stretcher;

  localparam int H    = 4;
  localparam int G    = 2;
  localparam int PW   = 2;
  localparam int PMAX = 3;
`ifdef PULSE_STRETCH_RETRIGGER_EN
  localparam bit RETRIG = 1'b1;
`else
  localparam bit RETRIG = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sig_pulse = 1'b0;
  logic          ovf_clr = 1'b0;
  logic          sig_level;
  logic          busy;
  logic [PW-1:0] pend_cnt;
  logic          ovf;

  pulse_stretcher #(
    .HIGH_CYCLES (H),
    .GAP_CYCLES  (G),
    .PEND_W      (PW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sig_pulse (sig_pulse),
    .ovf_clr   (ovf_clr),
    .sig_level (sig_level),
    .busy      (busy),
    .pend_cnt  (pend_cnt),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  int base = 0;
  bit chk_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Model: the current window is a timeline [m_s .. m_hi] high, (m_hi .. m_last] low.
  int m_s = -100;
  int m_hi = -100;
  int m_last = -100;
  int m_pend = 0;
  bit m_ovf = 1'b0;

  function automatic void m_start(input int t);
    m_s    = t;
    m_hi   = t + H - 1;
    m_last = t + H + G - 1;
  endfunction

  function automatic logic m_lvl(input int t);
    return (t >= m_s && t <= m_hi);
  endfunction

  function automatic logic m_busy(input int t);
    return (t >= m_s && t <= m_last);
  endfunction

  task automatic m_step(input int t, input logic p, input logic c);
    bit drop;
    drop = 1'b0;
    if (t > m_last) begin
      if (p) m_start(t + 1);
    end else if (t == m_last) begin
      if (m_pend > 0) begin
        m_start(t + 1);
        m_pend = m_pend - 1 + (p ? 1 : 0);
      end else if (p) begin
        m_start(t + 1);
      end
    end else if (RETRIG && t <= m_hi) begin
      if (p) begin
        m_hi   = t + H;
        m_last = m_hi + G;
      end
    end else if (p) begin
      if (m_pend == PMAX) drop = 1'b1;
      else m_pend = m_pend + 1;
    end
    m_ovf = drop ? 1'b1 : (c ? 1'b0 : m_ovf);
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_s = -100; m_hi = -100; m_last = -100; m_pend = 0; m_ovf = 1'b0;
    end else begin
      m_step(cyc, sig_pulse, ovf_clr);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      vectors = vectors + 1;
      if (sig_level !== m_lvl(cyc) || busy !== m_busy(cyc) ||
          pend_cnt !== PW'(m_pend) || ovf !== m_ovf) begin
        miscompares = miscompares + 1;
        $display("FAIL cycle_check @%0d: got lvl=%b busy=%b pend=%0d ovf=%b, model lvl=%b busy=%b pend=%0d ovf=%b",
                 cyc - base, sig_level, busy, pend_cnt, ovf, m_lvl(cyc), m_busy(cyc), m_pend, m_ovf);
      end
    end
  end

  task automatic step(input logic p, input logic c);
    sig_pulse = p;
    ovf_clr   = c;
    @(posedge clk);
    #1;
    sig_pulse = 1'b0;
    ovf_clr   = 1'b0;
  endtask

  task automatic run_until(input int t);
    while (cyc < t) step(1'b0, 1'b0);
  endtask

  task automatic pulse_at(input int t);
    run_until(t);
    step(1'b1, 1'b0);
  endtask

  // Hand-computed expectation at relative cycle n; pins both the DUT and the model.
  task automatic lit(input string name, input int n, input logic l, input logic b,
                     input int p, input logic o);
    run_until(base + n);
    @(negedge clk);
    vectors = vectors + 1;
    if (sig_level !== l || busy !== b || pend_cnt !== PW'(p) || ovf !== o ||
        m_lvl(cyc) !== l || m_busy(cyc) !== b || m_pend != p || m_ovf !== o) begin
      miscompares = miscompares + 1;
      $display("FAIL %s @%0d: got lvl=%b busy=%b pend=%0d ovf=%b (model %b %b %0d %b), want lvl=%b busy=%b pend=%0d ovf=%b",
               name, n, sig_level, busy, pend_cnt, ovf, m_lvl(cyc), m_busy(cyc), m_pend, m_ovf, l, b, p, o);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    base = cyc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    lit("reset_state", 0, 1'b0, 1'b0, 0, 1'b0);

    // Single strobe
    do_reset();
    pulse_at(base + 10);
    lit("single_hi",   12, 1'b1, 1'b1, 0, 1'b0);
    lit("single_gap",  15, 1'b0, 1'b1, 0, 1'b0);
    lit("single_idle", 17, 1'b0, 1'b0, 0, 1'b0);

`ifndef PULSE_STRETCH_RETRIGGER_EN
    // Three strobes queue and replay
    do_reset();
    pulse_at(base + 10);
    pulse_at(base + 11);
    lit("tri_q1", 12, 1'b1, 1'b1, 1, 1'b0);
    pulse_at(base + 12);
    lit("tri_q2",   13, 1'b1, 1'b1, 2, 1'b0);
    lit("tri_w2",   17, 1'b1, 1'b1, 1, 1'b0);
    lit("tri_w3",   23, 1'b1, 1'b1, 0, 1'b0);
    lit("tri_idle", 29, 1'b0, 1'b0, 0, 1'b0);

    // Six strobes saturate the queue; clear coinciding with a drop keeps ovf
    do_reset();
    for (int i = 10; i <= 14; i++) pulse_at(base + i);
    lit("ovf_set", 15, 1'b0, 1'b1, 3, 1'b1);
    step(1'b1, 1'b1);
    lit("ovf_clr_vs_drop", 16, 1'b0, 1'b1, 3, 1'b1);
    lit("ovf_w4",          32, 1'b1, 1'b1, 0, 1'b1);
    lit("ovf_idle",        35, 1'b0, 1'b0, 0, 1'b1);
    run_until(base + 36);
    step(1'b0, 1'b1);
    lit("ovf_cleared",     37, 1'b0, 1'b0, 0, 1'b0);
`endif

    // Strobe in the last gap cycle: back-to-back window
    do_reset();
    pulse_at(base + 10);
    lit("b2b_gap_end", 16, 1'b0, 1'b1, 0, 1'b0);
    pulse_at(base + 16);
    lit("b2b_w2",      17, 1'b1, 1'b1, 0, 1'b0);
    lit("b2b_w2_gap",  21, 1'b0, 1'b1, 0, 1'b0);
    lit("b2b_idle",    23, 1'b0, 1'b0, 0, 1'b0);

    // Async reset mid-window, then a full window after release
    do_reset();
    pulse_at(base + 10);
    pulse_at(base + 11);
    run_until(base + 12);
    rst = 1'b1;
    lit("rst_async", 12, 1'b0, 1'b0, 0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    base = cyc;
    pulse_at(base + 3);
    lit("rst_after_hi",   4, 1'b1, 1'b1, 0, 1'b0);
    lit("rst_after_last", 7, 1'b1, 1'b1, 0, 1'b0);
    lit("rst_after_gap",  8, 1'b0, 1'b1, 0, 1'b0);

`ifdef PULSE_STRETCH_RETRIGGER_EN
    // Retrigger extends the window without queuing
    do_reset();
    pulse_at(base + 10);
    pulse_at(base + 13);
    lit("retrig_hold", 17, 1'b1, 1'b1, 0, 1'b0);
    lit("retrig_end",  18, 1'b0, 1'b1, 0, 1'b0);
`endif

    run_until(base + 30);
    @(negedge clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
